// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs, round-robin selection, registered Common Data Bus broadcast.
// Optional macro CDB_BYPASS_EN: with every FIFO empty, an incoming request goes straight to the CDB.
module cdb_arbiter #(
    parameter int NREQ      = 3,
    parameter int ROB_IDX_W = 4,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*ROB_IDX_W-1:0] req_rob_idx,
    input  logic [NREQ*DATA_W-1:0]    req_val,
    output logic                      cdb_valid,
    output logic [ROB_IDX_W-1:0]      cdb_rob_idx,
    output logic [DATA_W-1:0]         cdb_val,
    output logic [1:0]                cdb_src
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int ENT_W = ROB_IDX_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
    localparam logic [SRC_W-1:0] LAST = SRC_W'(NREQ - 1);

    logic [ENT_W-1:0]     mem_q    [NREQ][BUF_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q [NREQ];
    logic [PTR_W-1:0]     rd_ptr_d [NREQ];
    logic [PTR_W-1:0]     wr_ptr_q [NREQ];
    logic [PTR_W-1:0]     wr_ptr_d [NREQ];
    logic [CNT_W-1:0]     count_q  [NREQ];
    logic [CNT_W-1:0]     count_d  [NREQ];
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
    logic [DATA_W-1:0]    cdb_val_q, cdb_val_d;
    logic [1:0]           cdb_src_q, cdb_src_d;

    logic                 act;
    logic                 bypass;
    logic                 found;
    logic [SRC_W-1:0]     win_idx;
    logic [ENT_W-1:0]     win_entry;
    logic [NREQ-1:0]      nonempty;
    logic [NREQ-1:0]      push;
    logic [NREQ-1:0]      store;
    logic [NREQ-1:0]      pop;

    // Readiness looks only at the pre-edge count, so a full FIFO stays closed even while popping.
    always_comb begin
        act = rdy_in && !flush_in;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = act && (count_q[i] < FULL);
            nonempty[i]  = (count_q[i] != '0);
        end
        push = req_valid & req_ready;
    end

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        win_idx = '0;
        bypass  = 1'b0;
`ifdef CDB_BYPASS_EN
        bypass  = !(|nonempty) && (|push);
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && (bypass ? push[idx] : nonempty[idx])) begin
                found   = 1'b1;
                win_idx = SRC_W'(idx);
            end
        end
        win_entry = bypass ? {req_rob_idx[win_idx*ROB_IDX_W +: ROB_IDX_W],
                              req_val[win_idx*DATA_W +: DATA_W]}
                           : mem_q[win_idx][rd_ptr_q[win_idx]];

        for (int i = 0; i < NREQ; i++) begin
            pop[i]      = act && found && !bypass && (win_idx == SRC_W'(i));
            store[i]    = push[i] && !(bypass && (win_idx == SRC_W'(i)));
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(store[i]);
            count_d[i]  = count_q[i] + CNT_W'(store[i]) - CNT_W'(pop[i]);
            if (flush_in) begin
                rd_ptr_d[i] = '0;
                wr_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
        end

        cdb_valid_d   = cdb_valid_q;
        cdb_rob_idx_d = cdb_rob_idx_q;
        cdb_val_d     = cdb_val_q;
        cdb_src_d     = cdb_src_q;
        rr_ptr_d      = rr_ptr_q;
        if (flush_in) begin
            cdb_valid_d = 1'b0;
        end else if (rdy_in) begin
            cdb_valid_d = found;
            if (found) begin
                cdb_rob_idx_d = win_entry[ENT_W-1:DATA_W];
                cdb_val_d     = win_entry[DATA_W-1:0];
                cdb_src_d     = 2'(win_idx);
                rr_ptr_d      = (win_idx == LAST) ? '0 : win_idx + SRC_W'(1);
            end
        end
    end

    // NOTE: FIFO storage is not reset; count_q gates every read, so stale words are never observed.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NREQ; i++) begin
            if (store[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W],
                                          req_val[i*DATA_W +: DATA_W]};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NREQ; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q      <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_rob_idx_q <= '0;
            cdb_val_q     <= '0;
            cdb_src_q     <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            rr_ptr_q      <= rr_ptr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_idx_q <= cdb_rob_idx_d;
            cdb_val_q     <= cdb_val_d;
            cdb_src_q     <= cdb_src_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_idx = cdb_rob_idx_q;
    assign cdb_val     = cdb_val_q;
    assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed-vector bench for cdb_arbiter in its default (non-bypass) build.
module tb_cdb_arbiter;
    logic        clk_in;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [11:0] req_rob_idx;
    logic [95:0] req_val;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_idx;
    logic [31:0] cdb_val;
    logic [1:0]  cdb_src;

    int n_vec = 0;
    int n_err = 0;

    cdb_arbiter dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rob_idx (req_rob_idx),
        .req_val     (req_val),
        .cdb_valid   (cdb_valid),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_val     (cdb_val),
        .cdb_src     (cdb_src)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected CDB contents; payload fields are compared only when a broadcast is expected.
    task automatic cdb_chk(input string tag, input logic v, input logic [3:0] rob,
                           input logic [31:0] val, input logic [1:0] src);
        check({tag, ".valid"}, 64'(cdb_valid), 64'(v));
        if (v) begin
            check({tag, ".rob"}, 64'(cdb_rob_idx), 64'(rob));
            check({tag, ".val"}, 64'(cdb_val), 64'(val));
            check({tag, ".src"}, 64'(cdb_src), 64'(src));
        end
    endtask

    task automatic ready_chk(input string tag, input logic [2:0] exp);
        #1;
        check(tag, 64'(req_ready), 64'(exp));
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] rob, input logic [31:0] val);
        req_valid[i]         = 1'b1;
        req_rob_idx[i*4 +: 4] = rob;
        req_val[i*32 +: 32]   = val;
    endtask

    task automatic clr_req();
        req_valid = 3'b000;
    endtask

    initial begin
        // Reset held with all sources requesting
        rst_n_in    = 1'b0;
        rdy_in      = 1'b1;
        flush_in    = 1'b0;
        req_valid   = 3'b000;
        req_rob_idx = '0;
        req_val     = '0;
        set_req(0, 4'hA, 32'h1111_1111);
        set_req(1, 4'hB, 32'h2222_2222);
        set_req(2, 4'hC, 32'h3333_3333);
        tick();
        tick();
        cdb_chk("rst_hold", 1'b0, 4'h0, 32'h0, 2'd0);
        check("rst_val", 64'(cdb_val), 64'h0);
        check("rst_rob", 64'(cdb_rob_idx), 64'h0);
        rst_n_in = 1'b1;
        clr_req();
        ready_chk("rst_ready", 3'b111);
        tick();
        cdb_chk("idle0", 1'b0, 4'h0, 32'h0, 2'd0);
        tick();
        cdb_chk("idle1", 1'b0, 4'h0, 32'h0, 2'd0);

        // Single result from source 1: visible after the second edge
        set_req(1, 4'd5, 32'hDEAD_BEEF);
        tick();
        cdb_chk("single_n", 1'b0, 4'h0, 32'h0, 2'd0);
        clr_req();
        tick();
        cdb_chk("single_n1", 1'b1, 4'd5, 32'hDEAD_BEEF, 2'd1);
        tick();
        cdb_chk("single_gap", 1'b0, 4'h0, 32'h0, 2'd0);

        // Source 2 alone wins and moves rr_ptr back to 0
        set_req(2, 4'd7, 32'h77);
        tick();
        clr_req();
        tick();
        cdb_chk("rr_prep", 1'b1, 4'd7, 32'h77, 2'd2);
        tick();
        cdb_chk("rr_prep_gap", 1'b0, 4'h0, 32'h0, 2'd0);

        // All three push at once, rr_ptr=0: order 0,1,2
        set_req(0, 4'd1, 32'hA1);
        set_req(1, 4'd2, 32'hA2);
        set_req(2, 4'd3, 32'hA3);
        tick();
        cdb_chk("rr3_push", 1'b0, 4'h0, 32'h0, 2'd0);
        clr_req();
        tick();
        cdb_chk("rr3_a", 1'b1, 4'd1, 32'hA1, 2'd0);
        tick();
        cdb_chk("rr3_b", 1'b1, 4'd2, 32'hA2, 2'd1);
        tick();
        cdb_chk("rr3_c", 1'b1, 4'd3, 32'hA3, 2'd2);
        tick();
        cdb_chk("rr3_gap", 1'b0, 4'h0, 32'h0, 2'd0);

        // Sources 0 and 2: order 0 then 2
        set_req(0, 4'd4, 32'hB0);
        set_req(2, 4'd6, 32'hB2);
        tick();
        clr_req();
        tick();
        cdb_chk("rr2_a", 1'b1, 4'd4, 32'hB0, 2'd0);
        tick();
        cdb_chk("rr2_b", 1'b1, 4'd6, 32'hB2, 2'd2);
        tick();
        cdb_chk("rr2_gap", 1'b0, 4'h0, 32'h0, 2'd0);

        // Backpressure on source 0 while sources 1 and 2 contend
        set_req(1, 4'd8, 32'h21);
        set_req(2, 4'd9, 32'h31);
        tick();
        clr_req();
        set_req(0, 4'd12, 32'h10);
        ready_chk("bp_rdy_p2", 3'b111);
        tick();
        cdb_chk("bp_p2", 1'b1, 4'd8, 32'h21, 2'd1);
        set_req(0, 4'd13, 32'h11);
        set_req(1, 4'd10, 32'h22);
        ready_chk("bp_rdy_p3", 3'b111);
        tick();
        cdb_chk("bp_p3", 1'b1, 4'd9, 32'h31, 2'd2);
        clr_req();
        set_req(0, 4'd14, 32'h12);
        ready_chk("bp_full0", 3'b110);
        tick();
        cdb_chk("bp_p4", 1'b1, 4'd12, 32'h10, 2'd0);
        ready_chk("bp_rdy_p5", 3'b111);
        tick();
        cdb_chk("bp_p5", 1'b1, 4'd10, 32'h22, 2'd1);
        clr_req();
        ready_chk("bp_full1", 3'b110);
        tick();
        cdb_chk("bp_p6", 1'b1, 4'd13, 32'h11, 2'd0);
        tick();
        cdb_chk("bp_p7", 1'b1, 4'd14, 32'h12, 2'd0);
        tick();
        cdb_chk("bp_gap", 1'b0, 4'h0, 32'h0, 2'd0);

        // Flush with four entries buffered (rr_ptr=1 here)
        set_req(0, 4'd1, 32'h50);
        set_req(1, 4'd2, 32'h51);
        set_req(2, 4'd3, 32'h52);
        tick();
        clr_req();
        set_req(0, 4'd4, 32'h53);
        set_req(1, 4'd5, 32'h54);
        tick();
        cdb_chk("fl_pre", 1'b1, 4'd2, 32'h51, 2'd1);
        clr_req();
        flush_in = 1'b1;
        set_req(2, 4'd6, 32'h5F);
        ready_chk("fl_rdy_during", 3'b000);
        tick();
        cdb_chk("fl_after", 1'b0, 4'h0, 32'h0, 2'd0);
        flush_in = 1'b0;
        clr_req();
        ready_chk("fl_rdy_after", 3'b111);
        tick();
        cdb_chk("fl_empty", 1'b0, 4'h0, 32'h0, 2'd0);
        set_req(0, 4'd7, 32'h60);
        set_req(1, 4'd8, 32'h61);
        set_req(2, 4'd9, 32'h62);
        tick();
        cdb_chk("fl_push", 1'b0, 4'h0, 32'h0, 2'd0);
        clr_req();
        tick();
        cdb_chk("fl_rr_a", 1'b1, 4'd9, 32'h62, 2'd2);
        tick();
        cdb_chk("fl_rr_b", 1'b1, 4'd7, 32'h60, 2'd0);
        tick();
        cdb_chk("fl_rr_c", 1'b1, 4'd8, 32'h61, 2'd1);
        tick();
        cdb_chk("fl_gap", 1'b0, 4'h0, 32'h0, 2'd0);

        // Pause for 3 cycles while 0x42 is on the bus (rr_ptr=2 here)
        set_req(2, 4'd2, 32'h42);
        set_req(0, 4'd3, 32'h43);
        set_req(1, 4'd4, 32'h44);
        tick();
        clr_req();
        tick();
        cdb_chk("pz_first", 1'b1, 4'd2, 32'h42, 2'd2);
        rdy_in = 1'b0;
        set_req(1, 4'd15, 32'h99);
        ready_chk("pz_rdy", 3'b000);
        for (int c = 0; c < 3; c++) begin
            tick();
            cdb_chk("pz_hold", 1'b1, 4'd2, 32'h42, 2'd2);
        end
        rdy_in = 1'b1;
        clr_req();
        tick();
        cdb_chk("pz_res_a", 1'b1, 4'd3, 32'h43, 2'd0);
        tick();
        cdb_chk("pz_res_b", 1'b1, 4'd4, 32'h44, 2'd1);
        tick();
        cdb_chk("pz_gap", 1'b0, 4'h0, 32'h0, 2'd0);

        // Asynchronous reset between edges while a broadcast is live
        set_req(0, 4'd6, 32'h77);
        tick();
        clr_req();
        tick();
        cdb_chk("ar_live", 1'b1, 4'd6, 32'h77, 2'd0);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("ar_valid", 64'(cdb_valid), 64'h0);
        check("ar_rob", 64'(cdb_rob_idx), 64'h0);
        check("ar_val", 64'(cdb_val), 64'h0);
        check("ar_src", 64'(cdb_src), 64'h0);
        #10;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus between the execution-side producers (ALU, LSB, branch unit) that complete instructions out of order.
- Each producer pushes {ROB index, result} into a small per-source FIFO.
- Round-robin arbitration selects one entry per cycle. The winner is broadcast on a registered CDB that RS, LSB and ROB snoop to wake renamed operands.
- flush_in discards all in-flight results on misprediction.

Parameters:
NREQ, 3, number of producers (0=ALU, 1=LSB, 2=BRU)
ROB_IDX_W, 4, ROB reorder index width
DATA_W, 32, result width
BUF_DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global enable; 0 = pause
flush_in  input  1  synchronous flush (mispredict)
req_valid  input  NREQ  per-source result valid
req_ready  output  NREQ  per-source accept
req_rob_idx  input  NREQ*ROB_IDX_W  flat; source i at [i*ROB_IDX_W +: ROB_IDX_W]
req_val  input  NREQ*DATA_W  flat; source i at [i*DATA_W +: DATA_W]
cdb_valid  output  1  broadcast valid (one-cycle pulse per entry)
cdb_rob_idx  output  ROB_IDX_W  ROB index being resolved
cdb_val  output  DATA_W  result value
cdb_src  output  2  winning source number

Behaviour:
- Reset (rst_n_in=0, asynchronous, takes effect at any time including mid-transfer):
  - all FIFOs empty, rr_ptr=0;
  - cdb_valid=0, cdb_rob_idx=0, cdb_val=0, cdb_src=0.
- req_ready[i] is combinational: rdy_in && !flush_in && count[i] < BUF_DEPTH.
  - Uses the count before any same-cycle pop.
  - A full FIFO therefore stays not-ready in a cycle where it is also popped.
- Push: at a rising edge with req_valid[i] && req_ready[i], append the entry to FIFO i.
  - FIFO order per source is preserved.
  - req_valid without req_ready has no effect; the producer must hold its data.
- Arbitration (edge with rdy_in=1, flush_in=0):
  - scan sources from rr_ptr upward, wrapping at NREQ;
  - the first non-empty FIFO wins, considering pre-edge contents only;
  - winner head is popped and registered to cdb_* with cdb_valid=1;
  - rr_ptr <= (winner+1) mod NREQ.
- If no FIFO is non-empty: cdb_valid <= 0; other cdb_* fields hold; rr_ptr holds.
- Latency: entry pushed at edge N into an empty FIFO, with no higher-priority contender, appears on CDB after edge N+1. Each entry is broadcast exactly once.
- Throughput: one broadcast per cycle.
  - Starvation bound: a non-empty source waits at most NREQ-1 broadcasts.
- Simultaneous push and pop on the same FIFO at one edge: both happen; count unchanged.
- flush_in=1 at an edge:
  - all FIFO counts and pointers cleared; same-edge pushes dropped;
  - cdb_valid <= 0; rr_ptr unchanged;
  - flush has priority over rdy_in.
- rdy_in=0, flush_in=0:
  - no push, no pop;
  - all state and all cdb_* outputs hold (including cdb_valid).
- Per-source FIFO pointers wrap modulo BUF_DEPTH.
- count width is clog2(BUF_DEPTH)+1, so a full FIFO is distinguishable from an empty one.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- Defined:
  - If every FIFO is empty before the edge and some req_valid[i] && req_ready[i] is high, the arbiter picks among these incoming requests in rr order.
  - The winner is written directly to cdb_* at that edge (latency 0 edges after handshake) and is not stored.
  - Losing incoming requests are pushed normally.
  - rr_ptr updates as for a FIFO winner.
- Undefined: all requests go through the FIFOs; latency as above.

Test Plan:
1. Reset: hold rst_n_in=0 with req_valid=3'b111 -> cdb_valid=0, cdb_val=0; after release, idle inputs -> cdb_valid stays 0 and req_ready=3'b111.
2. Single result: source 1 pushes rob=5, val=32'hDEADBEEF at edge N -> cdb_valid=1, cdb_rob_idx=5, cdb_val=DEADBEEF, cdb_src=1 after edge N+1 (after edge N with CDB_BYPASS_EN), then cdb_valid=0 the next cycle.
3. Round-robin: all three push at once (rob 1,2,3) with rr_ptr=0 -> CDB shows src 0,1,2 on three consecutive cycles; next, sources 0 and 2 push -> order 0 then 2.
4. Backpressure: source 0 valid every cycle with vals 0x10,0x11,0x12 while sources 1 and 2 stay busy -> req_ready[0] drops to 0 at count 2; source 0 broadcasts 0x10,0x11,0x12 in order, none lost or duplicated.
5. Flush: four entries buffered, flush_in=1 for one cycle -> next cycle cdb_valid=0, req_ready=3'b111; none of the four appear afterwards; rr_ptr unchanged.
6. Pause: rdy_in=0 for 3 cycles while cdb_valid=1 with val 0x42 -> outputs hold 0x42 and req_ready=0; on resume, remaining entries continue in the same rr order.
